netdma_rx_writemaster: RTL and testbench

Receive-side write master of the netdma controller. It takes a buffer descriptor (address, capacity) from the dispatcher's write control, accepts one packet from the MAC-side Avalon-ST stream, and writes it word by word into host memory over Avalon-MM. On completion it reports the byte count and status back to the dispatcher. It sits directly downstream of `netdma_dispatcher`, which drives `rx_master_control_o` and consumes `rx_master_response_i`; the top level packs and unpacks this block's `ctrl_*`/`resp_*` ports into those structs.

---
 rtl/netdma_rx_writemaster_if.sv | 42 ++++
 rtl/netdma_rx_writemaster.sv | 214 +++++++++++++++++++++
 tb/tb_netdma_rx_writemaster.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/netdma_rx_writemaster_if.sv
// +--------------------------------------------------------------------------+
// | netdma_rx_writemaster_if : Avalon-ST sink + Avalon-MM write bus bundle    |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface netdma_rx_writemaster_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int EMPTY_W = $clog2(DATA_W/8)
);
  logic [DATA_W-1:0]   snk_data_i;
  logic                snk_valid_i;
  logic                snk_sop_i;
  logic                snk_eop_i;
  logic [EMPTY_W-1:0]  snk_empty_i;
  logic                snk_error_i;
  logic                snk_ready_o;

  logic [ADDR_W-1:0]   mm_address_o;
  logic                mm_write_o;
  logic [DATA_W-1:0]   mm_writedata_o;
  logic [DATA_W/8-1:0] mm_byteenable_o;
  logic                mm_waitrequest_i;

  // master: the write-master block itself; slave: stream source + memory side
  modport master (
    input  snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i, snk_error_i,
    output snk_ready_o,
    output mm_address_o, mm_write_o, mm_writedata_o, mm_byteenable_o,
    input  mm_waitrequest_i
  );

  modport slave (
    output snk_data_i, snk_valid_i, snk_sop_i, snk_eop_i, snk_empty_i, snk_error_i,
    input  snk_ready_o,
    input  mm_address_o, mm_write_o, mm_writedata_o, mm_byteenable_o,
    output mm_waitrequest_i
  );
endinterface

`default_nettype wire

// File: rtl/netdma_rx_writemaster.sv
// +--------------------------------------------------------------------------+
// | netdma_rx_writemaster : writes one received packet into a host buffer     |
// | Optional macro NETDMA_RX_OVERFLOW_DROP_EN drains overflowing packets.     |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module netdma_rx_writemaster #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 16,
  parameter int EMPTY_W = $clog2(DATA_W/8)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ctrl_start_i,
  input  logic [ADDR_W-1:0]     ctrl_addr_i,
  input  logic [LEN_W-1:0]      ctrl_len_i,
  output logic                  busy_o,
  output logic                  resp_done_o,
  output logic [LEN_W-1:0]      resp_bytes_o,
  output logic                  resp_eop_o,
  output logic                  resp_overflow_o,
  output logic                  resp_error_o,
  netdma_rx_writemaster_if.master bus
);

  localparam int C_BYTES = DATA_W/8;
  localparam int C_OFF_W = $clog2(C_BYTES);

  typedef logic [LEN_W:0] len_ext_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SOP = 3'd1,
    S_XFER     = 3'd2,
`ifdef NETDMA_RX_OVERFLOW_DROP_EN
    S_DRAIN    = 3'd3,
`endif
    S_DONE     = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    words_left_q, words_left_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   mm_address_q, mm_address_d;
  logic                mm_write_q, mm_write_d;
  logic [DATA_W-1:0]   mm_writedata_q, mm_writedata_d;
  logic [C_BYTES-1:0]  mm_byteenable_q, mm_byteenable_d;
  logic [LEN_W-1:0]    bytes_q, bytes_d;
  logic                eop_q, eop_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic                done_q, done_d;

  logic                snk_ready;
  logic                accept;
  logic                mm_free;
  len_ext_t            beat_bytes;
  len_ext_t            bytes_sum;
  logic [C_BYTES-1:0]  be_all;

  assign mm_free = !mm_write_q || !bus.mm_waitrequest_i;
  assign be_all  = '1;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    words_left_d    = words_left_q;
    len_d           = len_q;
    mm_address_d    = mm_address_q;
    mm_write_d      = mm_write_q;
    mm_writedata_d  = mm_writedata_q;
    mm_byteenable_d = mm_byteenable_q;
    bytes_d         = bytes_q;
    eop_d           = eop_q;
    ovf_d           = ovf_q;
    err_d           = err_q;
    done_d          = 1'b0;
    snk_ready       = 1'b0;
    accept          = 1'b0;
    beat_bytes      = len_ext_t'(C_BYTES);
    bytes_sum       = '0;

    if (mm_write_q && !bus.mm_waitrequest_i) begin
      mm_write_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_start_i) begin
          addr_d       = ctrl_addr_i & ~ADDR_W'(C_BYTES - 1);
          // ceil(len / bytes-per-word) without widening the length
          words_left_d = (ctrl_len_i >> C_OFF_W) + LEN_W'(|ctrl_len_i[C_OFF_W-1:0]);
          len_d        = ctrl_len_i;
          bytes_d      = '0;
          eop_d        = 1'b0;
          ovf_d        = 1'b0;
          err_d        = 1'b0;
          if (ctrl_len_i == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_SOP;
          end
        end
      end
      S_WAIT_SOP: begin
        snk_ready = 1'b1;
        accept    = bus.snk_valid_i && bus.snk_sop_i;
      end
      S_XFER: begin
        snk_ready = (words_left_q != '0) && mm_free;
        accept    = snk_ready && bus.snk_valid_i;
      end
`ifdef NETDMA_RX_OVERFLOW_DROP_EN
      S_DRAIN: begin
        snk_ready = 1'b1;
        if (bus.snk_valid_i) begin
          if (bus.snk_error_i) err_d = 1'b1;
          if (bus.snk_eop_i) state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        // done fires once the final write has left; the state exits the cycle after
        if (done_q) begin
          state_d = S_IDLE;
        end else if (mm_free) begin
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      mm_write_d     = 1'b1;
      mm_address_d   = addr_q;
      mm_writedata_d = bus.snk_data_i;
      addr_d         = addr_q + ADDR_W'(C_BYTES);
      words_left_d   = words_left_q - 1'b1;
      if (bus.snk_eop_i) begin
        mm_byteenable_d = be_all >> bus.snk_empty_i;
        beat_bytes      = len_ext_t'(C_BYTES) - len_ext_t'(bus.snk_empty_i);
      end else begin
        mm_byteenable_d = be_all;
      end
      bytes_sum = len_ext_t'(bytes_q) + beat_bytes;
      bytes_d   = (bytes_sum > len_ext_t'(len_q)) ? len_q : bytes_sum[LEN_W-1:0];
      if (bus.snk_error_i) err_d = 1'b1;
      if (bus.snk_eop_i) begin
        eop_d   = 1'b1;
        state_d = S_DONE;
      end else if (words_left_q == LEN_W'(1)) begin
        ovf_d   = 1'b1;
`ifdef NETDMA_RX_OVERFLOW_DROP_EN
        state_d = S_DRAIN;
`else
        state_d = S_DONE;
`endif
      end else begin
        state_d = S_XFER;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      words_left_q    <= '0;
      len_q           <= '0;
      mm_address_q    <= '0;
      mm_write_q      <= 1'b0;
      mm_writedata_q  <= '0;
      mm_byteenable_q <= '0;
      bytes_q         <= '0;
      eop_q           <= 1'b0;
      ovf_q           <= 1'b0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      words_left_q    <= words_left_d;
      len_q           <= len_d;
      mm_address_q    <= mm_address_d;
      mm_write_q      <= mm_write_d;
      mm_writedata_q  <= mm_writedata_d;
      mm_byteenable_q <= mm_byteenable_d;
      bytes_q         <= bytes_d;
      eop_q           <= eop_d;
      ovf_q           <= ovf_d;
      err_q           <= err_d;
      done_q          <= done_d;
    end
  end

  assign busy_o              = (state_q != S_IDLE);
  assign resp_done_o         = done_q;
  assign resp_bytes_o        = bytes_q;
  assign resp_eop_o          = eop_q;
  assign resp_overflow_o     = ovf_q;
  assign resp_error_o        = err_q;
  assign bus.snk_ready_o     = snk_ready;
  assign bus.mm_address_o    = mm_address_q;
  assign bus.mm_write_o      = mm_write_q;
  assign bus.mm_writedata_o  = mm_writedata_q;
  assign bus.mm_byteenable_o = mm_byteenable_q;

endmodule

`default_nettype wire

// File: tb/tb_netdma_rx_writemaster.sv
// +--------------------------------------------------------------------------+
// | tb_netdma_rx_writemaster : directed bench for netdma_rx_writemaster       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_netdma_rx_writemaster;

  logic        clk;
  logic        rst;
  logic        ctrl_start;
  logic [31:0] ctrl_addr;
  logic [15:0] ctrl_len;
  logic        busy;
  logic        resp_done;
  logic [15:0] resp_bytes;
  logic        resp_eop;
  logic        resp_overflow;
  logic        resp_error;

  int total = 0;
  int bad   = 0;

  netdma_rx_writemaster_if #(.DATA_W(64), .ADDR_W(32)) bus ();

  netdma_rx_writemaster #(.DATA_W(64), .ADDR_W(32), .LEN_W(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ctrl_start_i    (ctrl_start),
    .ctrl_addr_i     (ctrl_addr),
    .ctrl_len_i      (ctrl_len),
    .busy_o          (busy),
    .resp_done_o     (resp_done),
    .resp_bytes_o    (resp_bytes),
    .resp_eop_o      (resp_eop),
    .resp_overflow_o (resp_overflow),
    .resp_error_o    (resp_error),
    .bus             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory-side write log and done-pulse counter
  logic [31:0] wr_addr [0:63];
  logic [63:0] wr_data [0:63];
  logic [7:0]  wr_be   [0:63];
  int          wr_n   = 0;
  int          done_n = 0;

  always @(posedge clk) begin
    if (!rst && bus.mm_write_o && !bus.mm_waitrequest_i && wr_n < 64) begin
      wr_addr[wr_n] <= bus.mm_address_o;
      wr_data[wr_n] <= bus.mm_writedata_o;
      wr_be[wr_n]   <= bus.mm_byteenable_o;
      wr_n          <= wr_n + 1;
    end
    if (!rst && resp_done) done_n <= done_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [31:0] a, input logic [15:0] l);
    ctrl_start = 1'b1;
    ctrl_addr  = a;
    ctrl_len   = l;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic beat(input logic [63:0] d, input logic sop, input logic eop,
                      input logic [2:0] empty, input logic err);
    int n;
    bus.snk_data_i  = d;
    bus.snk_sop_i   = sop;
    bus.snk_eop_i   = eop;
    bus.snk_empty_i = empty;
    bus.snk_error_i = err;
    bus.snk_valid_i = 1'b1;
    #1;
    n = 0;
    while (!bus.snk_ready_o && n < 50) begin
      tick();
      n++;
    end
    chk("beat_accept", bus.snk_ready_o, 1'b1);
    tick();
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    bus.snk_eop_i   = 1'b0;
    bus.snk_empty_i = '0;
    bus.snk_error_i = 1'b0;
  endtask

  task automatic wait_done();
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      seen = resp_done;
      n++;
    end
    chk("done_seen", seen, 1'b1);
    tick();
    chk("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int d0;
    rst                  = 1'b1;
    ctrl_start           = 1'b0;
    ctrl_addr            = '0;
    ctrl_len             = '0;
    bus.snk_data_i       = '0;
    bus.snk_valid_i      = 1'b0;
    bus.snk_sop_i        = 1'b0;
    bus.snk_eop_i        = 1'b0;
    bus.snk_empty_i      = '0;
    bus.snk_error_i      = 1'b0;
    bus.mm_waitrequest_i = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_busy",  busy, 1'b0);
    chk("rst_ready", bus.snk_ready_o, 1'b0);
    chk("rst_write", bus.mm_write_o, 1'b0);
    chk("rst_done",  resp_done, 1'b0);
    chk("rst_bytes", resp_bytes, 16'd0);
    chk("rst_error", resp_error, 1'b0);
    rst = 1'b0;
    tick();

    // 24-byte packet, exact done latency
    base = wr_n;
    d0   = done_n;
    start(32'h0000_1000, 16'd64);
    chk("t1_busy",  busy, 1'b1);
    chk("t1_ready", bus.snk_ready_o, 1'b1);
    beat(64'h1111_1111_1111_1111, 1'b1, 1'b0, 3'd0, 1'b0);
    beat(64'h2222_2222_2222_2222, 1'b0, 1'b0, 3'd0, 1'b0);
    beat(64'h3333_3333_3333_3333, 1'b0, 1'b1, 3'd0, 1'b0);
    chk("t1_done_early", resp_done, 1'b0);
    tick();
    chk("t1_done_pulse", resp_done, 1'b1);
    chk("t1_busy_at_done", busy, 1'b1);
    tick();
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_done_low", resp_done, 1'b0);
    chk("t1_nwr",   wr_n - base, 3);
    chk("t1_addr0", wr_addr[base],   32'h0000_1000);
    chk("t1_addr1", wr_addr[base+1], 32'h0000_1008);
    chk("t1_addr2", wr_addr[base+2], 32'h0000_1010);
    chk("t1_data2", wr_data[base+2], 64'h3333_3333_3333_3333);
    chk("t1_be2",   wr_be[base+2], 8'hFF);
    chk("t1_bytes", resp_bytes, 16'd24);
    chk("t1_eop",   resp_eop, 1'b1);
    chk("t1_ovf",   resp_overflow, 1'b0);
    chk("t1_err",   resp_error, 1'b0);
    chk("t1_ndone", done_n - d0, 1);

    // 13-byte packet, partial last word
    base = wr_n;
    start(32'h0000_3000, 16'd64);
    beat(64'hA0A0_A0A0_A0A0_A0A0, 1'b1, 1'b0, 3'd0, 1'b0);
    beat(64'hB1B1_B1B1_B1B1_B1B1, 1'b0, 1'b1, 3'd3, 1'b0);
    wait_done();
    chk("t2_nwr",   wr_n - base, 2);
    chk("t2_be0",   wr_be[base], 8'hFF);
    chk("t2_be1",   wr_be[base+1], 8'h1F);
    chk("t2_addr1", wr_addr[base+1], 32'h0000_3008);
    chk("t2_bytes", resp_bytes, 16'd13);

    // memory back-pressure for 5 cycles mid-packet
    base = wr_n;
    start(32'h0000_2000, 16'd64);
    beat(64'hC0C0_C0C0_C0C0_C0C0, 1'b1, 1'b0, 3'd0, 1'b0);
    bus.mm_waitrequest_i = 1'b1;
    bus.snk_data_i       = 64'hC1C1_C1C1_C1C1_C1C1;
    bus.snk_valid_i      = 1'b1;
    #1;
    chk("t3_ready_blocked", bus.snk_ready_o, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_hold_write", bus.mm_write_o, 1'b1);
    chk("t3_hold_addr",  bus.mm_address_o, 32'h0000_2000);
    chk("t3_hold_data",  bus.mm_writedata_o, 64'hC0C0_C0C0_C0C0_C0C0);
    chk("t3_ready_held", bus.snk_ready_o, 1'b0);
    chk("t3_nwr_held",   wr_n - base, 0);
    bus.mm_waitrequest_i = 1'b0;
    beat(64'hC1C1_C1C1_C1C1_C1C1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("t3_addr_next", bus.mm_address_o, 32'h0000_2008);
    beat(64'hC2C2_C2C2_C2C2_C2C2, 1'b0, 1'b1, 3'd0, 1'b0);
    wait_done();
    chk("t3_nwr",   wr_n - base, 3);
    chk("t3_data0", wr_data[base],   64'hC0C0_C0C0_C0C0_C0C0);
    chk("t3_data1", wr_data[base+1], 64'hC1C1_C1C1_C1C1_C1C1);
    chk("t3_addr2", wr_addr[base+2], 32'h0000_2010);
    chk("t3_bytes", resp_bytes, 16'd24);

    // overflow: 16-byte buffer, 32-byte packet
    base = wr_n;
    start(32'h0000_4000, 16'd16);
    beat(64'hD0D0_D0D0_D0D0_D0D0, 1'b1, 1'b0, 3'd0, 1'b0);
    beat(64'hD1D1_D1D1_D1D1_D1D1, 1'b0, 1'b0, 3'd0, 1'b0);
`ifdef NETDMA_RX_OVERFLOW_DROP_EN
    beat(64'hD2D2_D2D2_D2D2_D2D2, 1'b0, 1'b0, 3'd0, 1'b0);
    beat(64'hD3D3_D3D3_D3D3_D3D3, 1'b0, 1'b1, 3'd0, 1'b0);
    wait_done();
`else
    wait_done();
    bus.snk_data_i  = 64'hD2D2_D2D2_D2D2_D2D2;
    bus.snk_valid_i = 1'b1;
    #1;
    chk("t4_ready_after", bus.snk_ready_o, 1'b0);
    tick();
    chk("t4_ready_after2", bus.snk_ready_o, 1'b0);
    bus.snk_valid_i = 1'b0;
`endif
    chk("t4_nwr",   wr_n - base, 2);
    chk("t4_ovf",   resp_overflow, 1'b1);
    chk("t4_eop",   resp_eop, 1'b0);
    chk("t4_bytes", resp_bytes, 16'd16);

    // junk before sop, error on second beat
    base = wr_n;
    start(32'h0000_5000, 16'd64);
    beat(64'hEEEE_0000_0000_0000, 1'b0, 1'b0, 3'd0, 1'b0);
    beat(64'hEEEE_1111_1111_1111, 1'b0, 1'b1, 3'd0, 1'b0);
    chk("t5_no_junk", wr_n - base, 0);
    beat(64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b0, 3'd0, 1'b0);
    beat(64'hF1F1_F1F1_F1F1_F1F1, 1'b0, 1'b0, 3'd0, 1'b1);
    beat(64'hF2F2_F2F2_F2F2_F2F2, 1'b0, 1'b1, 3'd0, 1'b0);
    wait_done();
    chk("t5_nwr",   wr_n - base, 3);
    chk("t5_addr0", wr_addr[base], 32'h0000_5000);
    chk("t5_data0", wr_data[base], 64'hF0F0_F0F0_F0F0_F0F0);
    chk("t5_err",   resp_error, 1'b1);
    chk("t5_bytes", resp_bytes, 16'd24);

    // zero-length descriptor
    base = wr_n;
    start(32'h0000_6000, 16'd0);
    bus.snk_data_i  = 64'h9999_9999_9999_9999;
    bus.snk_sop_i   = 1'b1;
    bus.snk_valid_i = 1'b1;
    #1;
    chk("t6_ready", bus.snk_ready_o, 1'b0);
    chk("t6_done_c1", resp_done, 1'b0);
    tick();
    chk("t6_done_c2", resp_done, 1'b1);
    chk("t6_err", resp_error, 1'b1);
    bus.snk_valid_i = 1'b0;
    bus.snk_sop_i   = 1'b0;
    tick();
    chk("t6_busy", busy, 1'b0);
    chk("t6_nwr", wr_n - base, 0);

    // reset in the middle of a transfer
    start(32'h0000_7000, 16'd64);
    beat(64'h7070_7070_7070_7070, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("t7_write_pending", bus.mm_write_o, 1'b1);
    bus.snk_valid_i = 1'b1;
    rst = 1'b1;
    tick();
    chk("t7_write", bus.mm_write_o, 1'b0);
    chk("t7_addr",  bus.mm_address_o, 32'h0);
    chk("t7_busy",  busy, 1'b0);
    chk("t7_ready", bus.snk_ready_o, 1'b0);
    chk("t7_bytes", resp_bytes, 16'd0);
    chk("t7_done",  resp_done, 1'b0);
    bus.snk_valid_i = 1'b0;
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
